// File: rtl/uart_pkg.sv
// Shared definitions for the SoC UART: register offsets, STAT bit positions,
// receiver state encoding and the DIV reset value.
package uart_pkg;

  localparam logic [7:0] OFF_DATA = 8'h00;
  localparam logic [7:0] OFF_DIV  = 8'h04;
  localparam logic [7:0] OFF_STAT = 8'h08;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVR       = 2;
  localparam int STAT_FERR      = 3;

  localparam logic [31:0] DIV_RESET = 32'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for the UART receiver: circular buffer with pointers one bit wider
// than the index. Pop takes priority, so a push into a full FIFO succeeds when popped.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic [7:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp[AW-1:0]];
  assign level   = 8'(wp - rp);

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver. Define UART_RX_FIFO_EN for a DEPTH-entry
// receive FIFO; otherwise a single holding register buffers one byte.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wen,
  input  logic        ren,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        irq
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx: DEPTH must be a power of two and at least 2");
  end

  logic        rx_meta;
  logic        rx_sync;
  rx_state_t   state;
  logic [31:0] div;
  logic [31:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        push;
  logic        ferr_evt;
  logic        ovr;
  logic        ferr;
  logic        full;
  logic        not_empty;
  logic [7:0]  level;
  logic [7:0]  head;
  logic [7:0]  off;
  logic        pop_req;
  logic        wr_div;
  logic        wr_stat;
  logic        push_ok;
  logic        ovr_evt;
  logic        unused_addr;

  assign off         = addr[7:0];
  assign unused_addr = ^addr[31:8];
  assign pop_req     = ren && (off == OFF_DATA);
  assign wr_div      = wen && (off == OFF_DIV);
  assign wr_stat     = wen && (off == OFF_STAT);
  assign push_ok     = push && (!full || pop_req);
  assign ovr_evt     = push && full && !pop_req;

`ifdef UART_RX_FIFO_EN
  logic empty;

  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop_req),
    .din   (shreg),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign not_empty = !empty;
`else
  logic [7:0] hold;
  logic       hold_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (push_ok) begin
      hold       <= shreg;
      hold_valid <= 1'b1;
    end else if (pop_req) begin
      hold_valid <= 1'b0;
    end
  end

  assign head      = hold;
  assign not_empty = hold_valid;
  assign full      = hold_valid;
  assign level     = {7'b0, hold_valid};
`endif

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Frame recovery; push/ferr_evt are one-cycle pulses consumed the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      push     <= 1'b0;
      ferr_evt <= 1'b0;
    end else begin
      push     <= 1'b0;
      ferr_evt <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_sync) begin
            cnt   <= div >> 1;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_sync) begin
            state <= ST_IDLE;
          end else begin
            cnt     <= div;
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg   <= {rx_sync, shreg[7:1]};
            cnt     <= div;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_sync) begin
            push  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            ferr_evt <= 1'b1;
            state    <= ST_WAIT_HIGH;
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_sync) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registers, sticky flags (a new event beats a same-cycle clear) and read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      div   <= DIV_RESET;
      ovr   <= 1'b0;
      ferr  <= 1'b0;
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      if (wr_div) div <= wdata;
      ovr  <= ovr_evt  || (ovr  && !(wr_stat && wdata[STAT_OVR]));
      ferr <= ferr_evt || (ferr && !(wr_stat && wdata[STAT_FERR]));
      irq  <= push_ok || (level > 8'd1) || (not_empty && !pop_req);
      if (ren) begin
        // NOTE: the default arm keeps every path assigned, so no latch or stale decode.
        case (off)
          OFF_DATA: rdata <= not_empty ? {23'b0, 1'b1, head} : 32'd0;
          OFF_DIV:  rdata <= div;
          OFF_STAT: rdata <= {16'b0, level, 4'b0, ferr, ovr, full, not_empty};
          default:  rdata <= 32'd0;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Memory-mapped UART receiver, the receive-side counterpart of the SoC's UART transmitter, decoded at 0x10000200–0x100002ff. It samples the asynchronous `rx` pin, recovers 8N1 frames using the same clock-divider convention as the transmitter, and buffers received bytes for the CPU. It presents a register interface shaped like the transmitter's, plus a read strobe so that reads can pop data.

## Interface
- `DEPTH`, 16: receive FIFO depth in bytes, power of two, at least 2. Used only when `UART_RX_FIFO_EN` is defined.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wen`  in  1  register write strobe, already qualified by address decode.
- `ren`  in  1  register read strobe, one cycle per CPU read, already qualified by address decode.
- `addr`  in  32  byte address; only `addr[7:0]` is decoded.
- `wdata`  in  32  write data.
- `rdata`  out  32  registered read data.
- `rx`  in  1  serial input; asynchronous; idles high.
- `irq`  out  1  high while at least one byte is buffered.

## Operation
- Register map:
  - 0x00 DATA (R): `{23'b0, valid, byte[7:0]}`. Reading pops one byte when not empty. Reading when empty returns 0 and does not pop.
  - 0x04 DIV (RW): bit period = DIV+1 clocks, identical to the transmitter convention. Reset value is 1.
  - 0x08 STAT: R = `{16'b0, level[7:0], 4'b0, ferr, ovr, full, not_empty}`. W = write-1-to-clear on bit 2 (`ovr`) and bit 3 (`ferr`).
- `rx` passes through a 2-flop synchronizer; both flops reset to 1.
- Bit counter behaviour: it loads a value and counts down; a sample is taken when it reaches 0.
- States:
  - IDLE: on synchronized `rx`==0, load `DIV>>1` and go to START.
  - START: at count 0, if `rx`==1 it was a glitch, so return to IDLE. Otherwise load DIV, clear the bit index, and go to DATA.
  - DATA: at each count 0, shift `rx` in LSB-first and reload DIV. After the 8th bit, go to STOP.
  - STOP: at count 0:
    - If `rx`==1, push the byte and go to IDLE.
    - If `rx`==0, discard the byte, set `ferr`, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx`==1, then go to IDLE. This prevents retriggering on a break condition.
- Push when full: the byte is dropped, `ovr` is set, and FIFO contents are unchanged.
- Push and pop in the same cycle:
  - When full, the pop happens first and the push succeeds; `ovr` is not set.
  - When empty, the push completes; the read returns the empty value 0.
- A W1C clear of `ferr`/`ovr` in the same cycle as a new error event: the set wins.
- A DIV write takes effect at the next counter load; frames in flight are not restarted. Software writes DIV only while idle.
- Reads of unmapped offsets return 0. Writes to unmapped offsets are ignored.
- Reset: state IDLE, FIFO empty, `ovr`=`ferr`=0, DIV=1, `rdata`=0, `irq`=0. Reset asserted mid-frame abandons the frame; the partial byte is never pushed.

## Timing
- `rdata` is valid on the cycle after the `ren` cycle, matching block-RAM read latency.
- A pop takes effect at the end of the `ren` cycle. STAT reads reflect state before any same-cycle push or pop.
- `irq` is registered. It rises 1 cycle after the push cycle and falls 1 cycle after the pop that empties the FIFO.
- Sample point is `DIV>>1`+1 clocks after the synchronized falling edge, then every DIV+1 clocks.
- Byte availability is about 2 synchronizer cycles + 9.5 bit periods after the falling edge on the pin.
- `level` width is 8 bits, zero-extended; `level`==DEPTH when full.

## Configuration
- `UART_RX_FIFO_EN` defined: DEPTH-entry circular FIFO with read/write pointers one bit wider than the index; full means the MSBs differ and the indices are equal.
- Not defined: single holding register, with `level` 0 or 1 and `full`==`not_empty`; the second unread byte sets `ovr`. The register map is identical in both builds.

## Structure
- Package `uart_pkg`:
  - register offsets (DATA/DIV/STAT);
  - STAT bit positions;
  - state encoding (IDLE, START, DATA, STOP, WAIT_HIGH);
  - DIV reset value.
- The transmitter adopts the same package.
- Sub-module `uart_rx_fifo`: byte FIFO with push/pop/full/empty/level. It is instantiated only under `UART_RX_FIFO_EN`.

## Test plan
- Reset then idle line -> STAT reads 0x00000000, `irq`=0, DATA reads 0.
- DIV=3, drive frame 0x55 (4 clocks/bit) -> `irq` rises; DATA reads 0x00000155; next STAT reads 0x00000000.
- DIV=3, 2-clock low glitch on `rx` -> no push, state back to IDLE, STAT remains 0.
- DIV=3, frame 0xA3 with stop bit low, held low 20 clocks -> STAT bit 3 set, no byte; write 0x8 to STAT -> `ferr` clears.
- FIFO build, DEPTH=4, send 5 bytes 0x01..0x05 without reading -> STAT = 0x0407 (level 4, ovr, full, not_empty); reads return 0x101..0x104.
- Full FIFO with a DATA read in the same cycle as the 5th push -> no `ovr`; level remains 4.
